tl_cntr_multi: RTL and testbench
================================

Name: tl_cntr_multi

Overview:
- Parametrised successor to the two-street traffic light controller. It drives N_WAY approaches, one green at a time, and hands green on round-robin according to vehicle sensors.
- Adds minimum and maximum green times, a timed yellow, and an all-red clearance interval.
- Moore FSM plus a phase timer. It sits at the top of the intersection logic and drives the lamp drivers directly.

Parameters:
- N_WAY, 2, number of approaches (>=1)
- GREEN_MIN, 8, minimum green duration in cycles (>=1)
- GREEN_MAX, 32, green duration after which a competing request forces handover (>=GREEN_MIN)
- YELLOW_T, 4, yellow duration in cycles (>=1)
- ALL_RED_T, 1, all-red clearance in cycles (0 = skipped)
- CNT_W, 8, phase timer width; must hold GREEN_MAX-1

Ports:
- clk, input, 1, system clock, rising edge
- reset, input, 1, synchronous active-high reset
- sensor, input, N_WAY, bit k = vehicle waiting on way k; already synchronised to clk
- light, output, 2*N_WAY, light[2k+1:2k] = lamp of way k: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED
- green_way, output, max(1,$clog2(N_WAY)), index of the way currently owning the phase (green or yellow)
- phase, output, 2, 2'b00 GREEN, 2'b01 YELLOW, 2'b10 ALL_RED

Behaviour:
- Reset is synchronous: reset high at a rising edge gives, after that edge:
  - state GREEN, cur_way = 0, next_way = 0, cnt = 0
  - light = way0 GREEN, all other ways RED
  - green_way = 0, phase = 2'b00
- Reset overrides every other condition, including mid-yellow or mid-all-red.
- Outputs are decoded purely from registered state, cur_way and cnt (Moore). There is no combinational path from sensor to outputs.
- Light decode:
  - GREEN: cur_way GREEN, others RED.
  - YELLOW: cur_way YELLOW, others RED.
  - ALL_RED: all ways RED.
- cnt clears to 0 on every state entry and increments each cycle in the state. In GREEN it saturates at GREEN_MAX-1.
- other_req = OR of sensor[j] for all j != cur_way. For N_WAY=1, other_req is always 0.
- GREEN exit, evaluated at each edge:
  - Condition: cnt >= GREEN_MIN-1 AND other_req AND (sensor[cur_way]==0 OR cnt == GREEN_MAX-1).
  - On exit: go to YELLOW and latch next_way = first j with sensor[j]=1, searching cur_way+1, cur_way+2, ... modulo N_WAY (rotating priority, cur_way excluded).
  - Green therefore lasts at least GREEN_MIN cycles, and at most GREEN_MAX cycles while another way is requesting.
- No competing request: GREEN holds indefinitely regardless of sensor[cur_way].
- A one-cycle request pulse present at a qualifying edge is sufficient to trigger exit. Requests are not stored. A pulse seen only before GREEN_MIN has elapsed is lost.
- YELLOW: exits after exactly YELLOW_T cycles (cnt == YELLOW_T-1).
  - ALL_RED_T > 0: goes to ALL_RED.
  - ALL_RED_T == 0: goes directly to GREEN with cur_way <= next_way.
- ALL_RED: exits after exactly ALL_RED_T cycles to GREEN, with cur_way <= next_way.
- Sensors are ignored during YELLOW and ALL_RED. next_way stays as latched even if its request drops, so the chosen way still receives green.
- Simultaneous requests are resolved only by rotating priority. No way is served twice while another way is continuously requesting.
- Illegal state encodings recover to GREEN with cur_way = 0 at the next edge.

Decomposition:
- Package tl_pkg holds:
  - light codes: L_GREEN=2'b00, L_YELLOW=2'b01, L_RED=2'b10
  - phase/state enum: S_GREEN, S_YELLOW, S_ALL_RED
- Sub-module tl_rr_pick (combinational): given sensor, cur_way and N_WAY, returns valid plus the next index under rotating priority excluding cur_way. valid is equivalent to other_req.
- Timer, FSM and light decode stay in tl_cntr_multi.

Test Plan (defaults unless noted):
1. Reset: hold reset 2 cycles, sensor=0 -> light=4'b1000, i.e. way1 RED, way0 GREEN; green_way=0, phase=0. Remains so for 100 cycles with sensor=0.
2. Basic handover: sensor=2'b10 from first cycle after reset -> 8 cycles way0 GREEN, 4 cycles YELLOW (light=4'b1001), 1 cycle ALL_RED (4'b1010), then way1 GREEN (4'b0010) and green_way=1 at cycle 13.
3. Max green: sensor=2'b11 held -> way0 GREEN for exactly 32 cycles, then yellow. Way1 then gets green and holds for 32 cycles before returning to way0.
4. Round-robin, N_WAY=4: sensor=4'b1010 at way0 -> next green is way1. Then sensor=4'b1001 -> next is way3 (way2 skipped). Then sensor=4'b0101 -> next is way0.
5. Reset mid-operation: assert reset during the 2nd yellow cycle -> after that edge, way0 GREEN, phase=0, cnt=0. A subsequent request on way1 needs a full 8-cycle green first.
6. Edge cases:
   - Single-cycle sensor[1] pulse at cycle 10 of green -> handover starts. A pulse at cycle 3 only -> no handover.
   - ALL_RED_T=0 -> YELLOW goes directly to GREEN of way1.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared definitions for the multi-way traffic light controller.
//   - Lamp codes driven onto each 2-bit lamp field.
//   - Phase/state enumeration; its encoding is also the external phase code.
//   - lamp_code(): lamp of one way given the phase and whether it owns it.
package tl_pkg;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    typedef enum logic [1:0] {
        S_GREEN   = 2'b00,
        S_YELLOW  = 2'b01,
        S_ALL_RED = 2'b10
    } tl_state_e;

    // Only the owning way ever shows green or yellow; everything else is red.
    function automatic logic [1:0] lamp_code(input tl_state_e st, input logic owner);
        logic [1:0] code;
        case (st)
            S_GREEN:  code = owner ? L_GREEN  : L_RED;
            S_YELLOW: code = owner ? L_YELLOW : L_RED;
            default:  code = L_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Rotating-priority picker (combinational).
//   sensor  : request vector, one bit per way
//   cur_way : way currently owning the phase (excluded from the search)
//   valid   : some other way is requesting
//   pick    : first requesting way after cur_way, wrapping modulo N_WAY
module tl_rr_pick #(
    parameter int N_WAY = 2,
    localparam int WAY_W = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
    input  logic [N_WAY-1:0] sensor,
    input  logic [WAY_W-1:0] cur_way,
    output logic             valid,
    output logic [WAY_W-1:0] pick
);

    int               idx_s;
    logic [N_WAY-1:0] sh_s;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        pick  = '0;
        idx_s = 0;
        sh_s  = '0;
        for (int k = N_WAY - 1; k >= 1; k--) begin
            idx_s = (int'(cur_way) + k) % N_WAY;
            sh_s  = sensor >> idx_s;
            valid = valid | sh_s[0];
            pick  = sh_s[0] ? WAY_W'(idx_s) : pick;
        end
    end

endmodule

// File: rtl/tl_cntr_multi.sv
// N-way traffic light controller: one green at a time, round-robin handover
// driven by vehicle sensors, with min/max green, timed yellow and optional
// all-red clearance. Outputs are registered and depend only on state.
//   clk, reset : clock and synchronous active-high reset
//   sensor     : vehicle-waiting flags, one per way (already synchronised)
//   light      : 2-bit lamp code per way, way k at light[2k+1:2k]
//   green_way  : way owning the current green/yellow phase
//   phase      : 2'b00 green, 2'b01 yellow, 2'b10 all-red
module tl_cntr_multi
    import tl_pkg::*;
#(
    parameter int N_WAY     = 2,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 4,
    parameter int ALL_RED_T = 1,
    parameter int CNT_W     = 8,
    localparam int WAY_W = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_WAY-1:0]     sensor,
    output logic [2*N_WAY-1:0]   light,
    output logic [WAY_W-1:0]     green_way,
    output logic [1:0]           phase
);

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'((ALL_RED_T > 0) ? ALL_RED_T - 1 : 0);

    tl_state_e        state_r,    state_s;
    logic [WAY_W-1:0] cur_way_r,  cur_way_s;
    logic [WAY_W-1:0] next_way_r, next_way_s;
    logic [CNT_W-1:0] cnt_r,      cnt_s;

    logic             other_req_s;
    logic [WAY_W-1:0] pick_s;
    logic [N_WAY-1:0] own_sh_s;
    logic             own_req_s;
    logic             green_exit_s;

    tl_rr_pick #(.N_WAY(N_WAY)) u_pick (
        .sensor  (sensor),
        .cur_way (cur_way_r),
        .valid   (other_req_s),
        .pick    (pick_s)
    );

    // Full lamp vector for a given phase and owning way.
    function automatic logic [2*N_WAY-1:0] decode_light(input tl_state_e st,
                                                        input logic [WAY_W-1:0] way);
        logic [2*N_WAY-1:0] l;
        l = '0;
        for (int k = 0; k < N_WAY; k++) begin
            l[2*k +: 2] = lamp_code(st, (k == int'(way)));
        end
        return l;
    endfunction

    // Green may be released once the minimum has elapsed and someone else
    // waits, but the owner keeps it while still demanding, up to the maximum.
    always_comb begin
        own_sh_s     = sensor >> cur_way_r;
        own_req_s    = own_sh_s[0];
        green_exit_s = (cnt_r >= GMIN_LAST) && other_req_s &&
                       (!own_req_s || (cnt_r == GMAX_LAST));
    end

    // Next-state and phase timer; cnt restarts on every state entry.
    always_comb begin
        state_s    = state_r;
        cur_way_s  = cur_way_r;
        next_way_s = next_way_r;
        cnt_s      = cnt_r;
        case (state_r)
            S_GREEN: begin
                if (green_exit_s) begin
                    state_s    = S_YELLOW;
                    next_way_s = pick_s;
                    cnt_s      = '0;
                end else begin
                    cnt_s = (cnt_r == GMAX_LAST) ? cnt_r : cnt_r + CNT_W'(1);
                end
            end
            S_YELLOW: begin
                if (cnt_r == YEL_LAST) begin
                    cnt_s = '0;
                    if (ALL_RED_T > 0) begin
                        state_s = S_ALL_RED;
                    end else begin
                        state_s   = S_GREEN;
                        cur_way_s = next_way_r;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_ALL_RED: begin
                if (cnt_r == AR_LAST) begin
                    state_s   = S_GREEN;
                    cur_way_s = next_way_r;
                    cnt_s     = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                // Corrupted encoding: restart cleanly from way 0 green.
                state_s    = S_GREEN;
                cur_way_s  = '0;
                next_way_s = '0;
                cnt_s      = '0;
            end
        endcase
    end

    // State registers; outputs are registered from the next-state values so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_GREEN;
            cur_way_r  <= '0;
            next_way_r <= '0;
            cnt_r      <= '0;
            light      <= decode_light(S_GREEN, '0);
            green_way  <= '0;
            phase      <= S_GREEN;
        end else begin
            state_r    <= state_s;
            cur_way_r  <= cur_way_s;
            next_way_r <= next_way_s;
            cnt_r      <= cnt_s;
            light      <= decode_light(state_s, cur_way_s);
            green_way  <= cur_way_s;
            phase      <= state_s;
        end
    end

endmodule

// File: tb/tb_tl_cntr_multi.sv
// Directed bench for tl_cntr_multi: three instances (2-way default, 4-way,
// 2-way without all-red) driven from one table of per-cycle expectations,
// plus bounded sequences for green latency and round-robin fairness.
module tb_tl_cntr_multi;

    logic       clk;
    logic       rst_a, rst_b, rst_c;
    logic [1:0] sens_a, sens_c;
    logic [3:0] sens_b;
    logic [3:0] light_a, light_c;
    logic [7:0] light_b;
    logic [0:0] gw_a, gw_c;
    logic [1:0] gw_b;
    logic [1:0] ph_a, ph_b, ph_c;

    int checks   = 0;
    int failures = 0;

    tl_cntr_multi #(.N_WAY(2)) dut_a (
        .clk(clk), .reset(rst_a), .sensor(sens_a),
        .light(light_a), .green_way(gw_a), .phase(ph_a)
    );

    tl_cntr_multi #(.N_WAY(4)) dut_b (
        .clk(clk), .reset(rst_b), .sensor(sens_b),
        .light(light_b), .green_way(gw_b), .phase(ph_b)
    );

    tl_cntr_multi #(.N_WAY(2), .ALL_RED_T(0)) dut_c (
        .clk(clk), .reset(rst_c), .sensor(sens_c),
        .light(light_c), .green_way(gw_c), .phase(ph_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic       rst;
        logic [3:0] sens;
        int         reps;
        logic [7:0] light;
        logic [1:0] gw;
        logic [1:0] ph;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int d, input logic r, input logic [3:0] s,
                                input int n, input logic [7:0] l,
                                input logic [1:0] g, input logic [1:0] p);
        vec_t v;
        v.dut = d; v.rst = r; v.sens = s; v.reps = n;
        v.light = l; v.gw = g; v.ph = p;
        return v;
    endfunction

    task automatic drive(input int d, input logic r, input logic [3:0] s);
        case (d)
            0:       begin rst_a = r; sens_a = s[1:0]; end
            1:       begin rst_b = r; sens_b = s;      end
            default: begin rst_c = r; sens_c = s[1:0]; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] l_act;
        logic [1:0] g_act, p_act;
        int n;
        logic [1:0] prev;
        logic [1:0] order [4];

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        sens_a = 2'b00; sens_b = 4'b0000; sens_c = 2'b00;
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // ---- DUT A (2 ways, all-red 1) ----
        // reset, then idle for 100 cycles
        tbl.push_back(mk(0, 1'b1, 4'b0000,   2, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0000, 100, 8'b1000, 2'd0, 2'd0));
        // basic handover to way1
        tbl.push_back(mk(0, 1'b1, 4'b0000,   1, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0010,   7, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0010,   4, 8'b1001, 2'd0, 2'd1));
        tbl.push_back(mk(0, 1'b0, 4'b0010,   1, 8'b1010, 2'd0, 2'd2));
        tbl.push_back(mk(0, 1'b0, 4'b0010,   1, 8'b0010, 2'd1, 2'd0));
        // both requesting: each green runs exactly 32 cycles
        tbl.push_back(mk(0, 1'b0, 4'b0011,  31, 8'b0010, 2'd1, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0011,   4, 8'b0110, 2'd1, 2'd1));
        tbl.push_back(mk(0, 1'b0, 4'b0011,   1, 8'b1010, 2'd1, 2'd2));
        tbl.push_back(mk(0, 1'b0, 4'b0011,  32, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0011,   2, 8'b1001, 2'd0, 2'd1));
        // reset at the end of the 2nd yellow cycle; way1 then waits a full green
        tbl.push_back(mk(0, 1'b1, 4'b0011,   1, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0010,   7, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0010,   1, 8'b1001, 2'd0, 2'd1));
        // early pulse lost, late pulse starts handover, next_way kept
        tbl.push_back(mk(0, 1'b1, 4'b0000,   1, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0000,   2, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0010,   1, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0000,   6, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(0, 1'b0, 4'b0010,   1, 8'b1001, 2'd0, 2'd1));
        tbl.push_back(mk(0, 1'b0, 4'b0000,   3, 8'b1001, 2'd0, 2'd1));
        tbl.push_back(mk(0, 1'b0, 4'b0000,   1, 8'b1010, 2'd0, 2'd2));
        tbl.push_back(mk(0, 1'b0, 4'b0000,   3, 8'b0010, 2'd1, 2'd0));

        // ---- DUT B (4 ways): rotating priority ----
        tbl.push_back(mk(1, 1'b1, 4'b0000,   1, 8'b10101000, 2'd0, 2'd0));
        tbl.push_back(mk(1, 1'b0, 4'b1010,   7, 8'b10101000, 2'd0, 2'd0));
        tbl.push_back(mk(1, 1'b0, 4'b1010,   4, 8'b10101001, 2'd0, 2'd1));
        tbl.push_back(mk(1, 1'b0, 4'b1010,   1, 8'b10101010, 2'd0, 2'd2));
        tbl.push_back(mk(1, 1'b0, 4'b1010,   1, 8'b10100010, 2'd1, 2'd0));
        tbl.push_back(mk(1, 1'b0, 4'b1001,   7, 8'b10100010, 2'd1, 2'd0));
        tbl.push_back(mk(1, 1'b0, 4'b1001,   4, 8'b10100110, 2'd1, 2'd1));
        tbl.push_back(mk(1, 1'b0, 4'b1001,   1, 8'b10101010, 2'd1, 2'd2));
        tbl.push_back(mk(1, 1'b0, 4'b1001,   1, 8'b00101010, 2'd3, 2'd0));
        tbl.push_back(mk(1, 1'b0, 4'b0101,   7, 8'b00101010, 2'd3, 2'd0));
        tbl.push_back(mk(1, 1'b0, 4'b0101,   4, 8'b01101010, 2'd3, 2'd1));
        tbl.push_back(mk(1, 1'b0, 4'b0101,   1, 8'b10101010, 2'd3, 2'd2));
        tbl.push_back(mk(1, 1'b0, 4'b0101,   1, 8'b10101000, 2'd0, 2'd0));

        // ---- DUT C (no all-red): yellow straight to green ----
        tbl.push_back(mk(2, 1'b1, 4'b0000,   1, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(2, 1'b0, 4'b0010,   7, 8'b1000, 2'd0, 2'd0));
        tbl.push_back(mk(2, 1'b0, 4'b0010,   4, 8'b1001, 2'd0, 2'd1));
        tbl.push_back(mk(2, 1'b0, 4'b0010,   2, 8'b0010, 2'd1, 2'd0));

        foreach (tbl[i]) begin
            drive(tbl[i].dut, tbl[i].rst, tbl[i].sens);
            for (int r = 0; r < tbl[i].reps; r++) begin
                tick();
                case (tbl[i].dut)
                    0:       begin l_act = {4'b0000, light_a}; g_act = {1'b0, gw_a}; p_act = ph_a; end
                    1:       begin l_act = light_b;            g_act = gw_b;         p_act = ph_b; end
                    default: begin l_act = {4'b0000, light_c}; g_act = {1'b0, gw_c}; p_act = ph_c; end
                endcase
                checks++;
                if (l_act !== tbl[i].light || g_act !== tbl[i].gw || p_act !== tbl[i].ph) begin
                    failures++;
                    $display("FAIL vec row=%0d rep=%0d dut=%0d light=%b/%b green_way=%0d/%0d phase=%0d/%0d (actual/required)",
                             i, r, tbl[i].dut, l_act, tbl[i].light, g_act, tbl[i].gw, p_act, tbl[i].ph);
                end
            end
        end
        drive(0, 1'b0, 4'b0000);
        drive(1, 1'b0, 4'b0000);
        drive(2, 1'b0, 4'b0000);

        // Green latency: edges from reset until yellow shows with way1 waiting.
        drive(0, 1'b1, 4'b0000);
        tick();
        drive(0, 1'b0, 4'b0010);
        n = 0;
        while (ph_a != 2'b01 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL green_latency cycles=%0d required=8", n);
        end

        // Fairness: all four ways requesting are served 1,2,3,0 in turn.
        order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;
        drive(1, 1'b1, 4'b0000);
        tick();
        drive(1, 1'b0, 4'b1111);
        prev = 2'd0;
        for (int s = 0; s < 4; s++) begin
            n = 0;
            while (!(ph_b == 2'b00 && gw_b != prev) && n < 60) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 60 || gw_b != order[s]) begin
                failures++;
                $display("FAIL rr_order step=%0d green_way=%0d required=%0d wait=%0d", s, gw_b, order[s], n);
            end
            prev = gw_b;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
